// File: rtl/initialization_command_word_sequencer.sv
// initialization_command_word_sequencer: decodes 8259A bus writes into ICW1-4/OCW1-3, holds ICW fields, strobes OCWs.
module initialization_command_word_sequencer #(
  parameter int CASCADE_LINES = 8,
  parameter bit SUPPORT_MCS80 = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     write_strobe,
  input  logic                     address_a0,
  input  logic [7:0]               internal_data_bus,
  output logic [2:0]               interrupt_vector_address,
  output logic                     level_or_edge_triggered_config,
  output logic                     call_address_interval_4_or_8_config,
  output logic                     single_or_cascade_config,
  output logic                     set_icw4_config,
  output logic [7:0]               interrupt_vector_address_high,
  output logic [CASCADE_LINES-1:0] cascade_device_config,
  output logic                     special_fully_nested_config,
  output logic                     buffered_mode_config,
  output logic                     buffered_master_or_slave_config,
  output logic                     auto_eoi_config,
  output logic                     microprocessor_mode_config,
  output logic                     initialization_start,
  output logic                     initialization_in_progress,
  output logic                     initialization_done,
  output logic                     write_operation_control_word_1,
  output logic                     write_operation_control_word_2,
  output logic                     write_operation_control_word_3
);
  typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  // Without MCS-80 support the part is 8086-only, so uPM idles at 1.
  localparam logic MPM_DEFAULT = ~SUPPORT_MCS80;
  state_t state, state_next;
  logic icw1, data_write, ocw1_next, ocw2_next, ocw3_next;
  assign icw1 = write_strobe & ~address_a0 & internal_data_bus[4];
  assign data_write = write_strobe & address_a0;
  assign ocw1_next = data_write & (state == READY);
  assign ocw2_next = write_strobe & ~address_a0 & ~internal_data_bus[4] & ~internal_data_bus[3] & (state == READY);
  assign ocw3_next = write_strobe & ~address_a0 & ~internal_data_bus[4] & internal_data_bus[3] & (state == READY);
  assign initialization_in_progress = (state == WAIT_ICW2) | (state == WAIT_ICW3) | (state == WAIT_ICW4);
  assign initialization_done = state == READY;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= UNINIT;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (icw1) state_next = WAIT_ICW2;
    else if (data_write)
      case (state)
        WAIT_ICW2: state_next = !single_or_cascade_config ? WAIT_ICW3 : set_icw4_config ? WAIT_ICW4 : READY;
        WAIT_ICW3: state_next = set_icw4_config ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_next = READY;
        default:   state_next = state;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      interrupt_vector_address            <= '0;
      level_or_edge_triggered_config      <= 1'b0;
      call_address_interval_4_or_8_config <= 1'b0;
      single_or_cascade_config            <= 1'b0;
      set_icw4_config                     <= 1'b0;
      interrupt_vector_address_high       <= '0;
      cascade_device_config               <= '0;
      special_fully_nested_config         <= 1'b0;
      buffered_mode_config                <= 1'b0;
      buffered_master_or_slave_config     <= 1'b0;
      auto_eoi_config                     <= 1'b0;
      microprocessor_mode_config          <= MPM_DEFAULT;
      initialization_start                <= 1'b0;
      write_operation_control_word_1      <= 1'b0;
      write_operation_control_word_2      <= 1'b0;
      write_operation_control_word_3      <= 1'b0;
    end else begin
      initialization_start           <= icw1;
      write_operation_control_word_1 <= ocw1_next;
      write_operation_control_word_2 <= ocw2_next;
      write_operation_control_word_3 <= ocw3_next;
      if (icw1) begin
        interrupt_vector_address            <= SUPPORT_MCS80 ? internal_data_bus[7:5] : 3'b000;
        level_or_edge_triggered_config      <= internal_data_bus[3];
        call_address_interval_4_or_8_config <= SUPPORT_MCS80 & internal_data_bus[2];
        single_or_cascade_config            <= internal_data_bus[1];
        set_icw4_config                     <= internal_data_bus[0];
        special_fully_nested_config         <= 1'b0;
        buffered_mode_config                <= 1'b0;
        buffered_master_or_slave_config     <= 1'b0;
        auto_eoi_config                     <= 1'b0;
        microprocessor_mode_config          <= MPM_DEFAULT;
      end else if (data_write && state == WAIT_ICW2) interrupt_vector_address_high <= internal_data_bus;
      else if (data_write && state == WAIT_ICW3) cascade_device_config <= internal_data_bus[CASCADE_LINES-1:0];
      else if (data_write && state == WAIT_ICW4) begin
        special_fully_nested_config     <= internal_data_bus[4];
        buffered_mode_config            <= internal_data_bus[3];
        buffered_master_or_slave_config <= internal_data_bus[2];
        auto_eoi_config                 <= internal_data_bus[1];
        microprocessor_mode_config      <= SUPPORT_MCS80 ? internal_data_bus[0] : 1'b1;
      end
    end
endmodule

// File: tb/tb_initialization_command_word_sequencer.sv
// tb_initialization_command_word_sequencer: strobe scoreboard plus directed field checks on two configurations.
module tb_initialization_command_word_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n, ws, a0, rst2_n, ws2, a02;
  logic [7:0] db, db2;
  logic [2:0] iva, iva2;
  logic ltim, adi, sngl, ic4, sfnm, buf_m, ms, aeoi, mpm, start, inprog, done, ocw1, ocw2, ocw3;
  logic ltim2, adi2, sngl2, ic42, sfnm2, buf2, ms2, aeoi2, mpm2, start2, inprog2, done2, o12, o22, o32;
  logic [7:0] ivah, ivah2, casc;
  logic [3:0] casc2;
  int total = 0, passed = 0;
  logic [3:0] exp_q[$];
  logic [3:0] seen, want;
  localparam logic [3:0] START = 4'b0001, OCW1 = 4'b0010, OCW2 = 4'b0100, OCW3 = 4'b1000;

  initialization_command_word_sequencer dut (
    .clock(clock), .reset_n(rst_n), .write_strobe(ws), .address_a0(a0), .internal_data_bus(db),
    .interrupt_vector_address(iva), .level_or_edge_triggered_config(ltim),
    .call_address_interval_4_or_8_config(adi), .single_or_cascade_config(sngl), .set_icw4_config(ic4),
    .interrupt_vector_address_high(ivah), .cascade_device_config(casc),
    .special_fully_nested_config(sfnm), .buffered_mode_config(buf_m), .buffered_master_or_slave_config(ms),
    .auto_eoi_config(aeoi), .microprocessor_mode_config(mpm), .initialization_start(start),
    .initialization_in_progress(inprog), .initialization_done(done),
    .write_operation_control_word_1(ocw1), .write_operation_control_word_2(ocw2),
    .write_operation_control_word_3(ocw3));

  initialization_command_word_sequencer #(.CASCADE_LINES(4), .SUPPORT_MCS80(1'b0)) dut2 (
    .clock(clock), .reset_n(rst2_n), .write_strobe(ws2), .address_a0(a02), .internal_data_bus(db2),
    .interrupt_vector_address(iva2), .level_or_edge_triggered_config(ltim2),
    .call_address_interval_4_or_8_config(adi2), .single_or_cascade_config(sngl2), .set_icw4_config(ic42),
    .interrupt_vector_address_high(ivah2), .cascade_device_config(casc2),
    .special_fully_nested_config(sfnm2), .buffered_mode_config(buf2), .buffered_master_or_slave_config(ms2),
    .auto_eoi_config(aeoi2), .microprocessor_mode_config(mpm2), .initialization_start(start2),
    .initialization_in_progress(inprog2), .initialization_done(done2),
    .write_operation_control_word_1(o12), .write_operation_control_word_2(o22),
    .write_operation_control_word_3(o32));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input bit addr, input logic [7:0] d, input bit second = 1'b0);
    if (second) begin ws2 = 1'b1; a02 = addr; db2 = d; end
    else begin ws = 1'b1; a0 = addr; db = d; end
    @(posedge clock);
    #1;
    ws = 1'b0;
    ws2 = 1'b0;
  endtask

  always @(negedge clock) begin
    seen = {ocw3, ocw2, ocw1, start};
    if (seen != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL strobe: got %b expected none", seen);
      else begin
        want = exp_q.pop_front();
        if (seen === want) passed++;
        else $display("FAIL strobe: got %b expected %b", seen, want);
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; ws = 1'b0; ws2 = 1'b0; a0 = 1'b0; a02 = 1'b0; db = '0; db2 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_done", {7'b0, done}, 8'h00);
    chk("rst_inprog", {7'b0, inprog}, 8'h00);
    chk("rst_mpm", {7'b0, mpm}, 8'h00);
    chk("rst_ivah", ivah, 8'h00);
    chk("rst_casc", casc, 8'h00);
    chk("rst_mpm2", {7'b0, mpm2}, 8'h01);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clock); #1;
    wr(1'b1, 8'hFF);
    chk("uninit_done", {7'b0, done}, 8'h00);
    exp_q.push_back(START);
    wr(1'b0, 8'h13);
    chk("icw1_inprog", {7'b0, inprog}, 8'h01);
    chk("icw1_sngl", {7'b0, sngl}, 8'h01);
    chk("icw1_ltim", {7'b0, ltim}, 8'h00);
    wr(1'b1, 8'h08);
    chk("icw2_ivah", ivah, 8'h08);
    chk("skip3_inprog", {7'b0, inprog}, 8'h01);
    wr(1'b1, 8'h01);
    chk("single_done", {7'b0, done}, 8'h01);
    chk("single_mpm", {7'b0, mpm}, 8'h01);
    exp_q.push_back(START);
    wr(1'b0, 8'h11);
    chk("icw1_clr_mpm", {7'b0, mpm}, 8'h00);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h04);
    chk("casc_mask", casc, 8'h04);
    chk("casc_not_done", {7'b0, done}, 8'h00);
    wr(1'b1, 8'h1D);
    chk("icw4_fields", {3'b0, sfnm, buf_m, ms, aeoi, mpm}, 8'h1D);
    chk("casc_done", {7'b0, done}, 8'h01);
    exp_q.push_back(OCW1); exp_q.push_back(OCW2); exp_q.push_back(OCW3);
    wr(1'b1, 8'hFB);
    wr(1'b0, 8'h20);
    wr(1'b0, 8'h0B);
    repeat (2) @(posedge clock); #1;
    exp_q.push_back(START);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h30);
    exp_q.push_back(START);
    wr(1'b0, 8'h1B);
    chk("restart_inprog", {7'b0, inprog}, 8'h01);
    chk("restart_ltim", {7'b0, ltim}, 8'h01);
    chk("restart_icw4_clr", {3'b0, sfnm, buf_m, ms, aeoi, mpm}, 8'h00);
    chk("restart_casc_kept", casc, 8'h04);
    wr(1'b1, 8'h48);
    chk("restart_ivah", ivah, 8'h48);
    chk("restart_wait4", {7'b0, inprog}, 8'h01);
    wr(1'b1, 8'h02);
    chk("restart_aeoi", {3'b0, sfnm, buf_m, ms, aeoi, mpm}, 8'h02);
    chk("restart_done", {7'b0, done}, 8'h01);
    exp_q.push_back(START);
    wr(1'b0, 8'hF6);
    chk("iva_adi", {4'b0, iva, adi}, 8'h0F);
    wr(1'b0, 8'h08);
    chk("wait_ignore", {7'b0, inprog}, 8'h01);
    wr(1'b1, 8'h55);
    chk("direct_ready", {7'b0, done}, 8'h01);
    chk("direct_ivah", ivah, 8'h55);
    wr(1'b0, 8'hF4, 1'b1);
    chk("m80_start", {7'b0, start2}, 8'h01);
    chk("m80_iva_adi", {4'b0, iva2, adi2}, 8'h00);
    wr(1'b1, 8'h40, 1'b1);
    chk("m80_ivah", ivah2, 8'h40);
    chk("m80_wait3", {7'b0, inprog2}, 8'h01);
    wr(1'b1, 8'hFA, 1'b1);
    chk("m80_casc", {4'b0, casc2}, 8'h0A);
    chk("m80_done", {7'b0, done2}, 8'h01);
    wr(1'b0, 8'hF5, 1'b1);
    wr(1'b1, 8'h40, 1'b1);
    wr(1'b1, 8'hFA, 1'b1);
    chk("m80_wait4", {7'b0, inprog2}, 8'h01);
    wr(1'b1, 8'h00, 1'b1);
    chk("m80_mpm_held", {7'b0, mpm2}, 8'h01);
    chk("m80_done2", {7'b0, done2}, 8'h01);
    wr(1'b0, 8'hF4, 1'b1);
    wr(1'b1, 8'h40, 1'b1);
    chk("m80_pre_rst", {7'b0, inprog2}, 8'h01);
    #2 rst2_n = 1'b0;
    #1;
    chk("arst_inprog", {7'b0, inprog2}, 8'h00);
    chk("arst_casc", {4'b0, casc2}, 8'h00);
    chk("arst_ivah", ivah2, 8'h00);
    chk("arst_mpm", {7'b0, mpm2}, 8'h01);
    chk("arst_cfg", {5'b0, ltim2, sngl2, ic42}, 8'h00);
    @(posedge clock); #1;
    rst2_n = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/initialization_command_word_sequencer.md
Name: initialization_command_word_sequencer

Overview:
- Next-generation initialization front end for the 8259A control logic.
- Decodes every bus write into ICW1, ICW2, ICW3, ICW4 or OCW1-3 using a sequencing state machine.
- Holds all ICW configuration fields in registers.
- Emits one-cycle OCW write strobes to the downstream IMR, priority and cascade logic.
- Parametrised in cascade-line count and in MCS-80 mode support.

Parameters:
CASCADE_LINES, 8, width of the ICW3 field and cascade_device_config output (2..8); slave ID uses the low clog2(CASCADE_LINES) bits.
SUPPORT_MCS80, 1, 1 = ADI and A7-A5 honoured; 0 = those fields forced to 0 and microprocessor_mode_config forced to 1 (8086 only).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
write_strobe  input  1  one-cycle pulse per CPU write; each high cycle is one distinct write.
address_a0  input  1  A0 of the write.
internal_data_bus  input  8  write data.
interrupt_vector_address  output  3  ICW1 D7-D5.
level_or_edge_triggered_config  output  1  ICW1 D3.
call_address_interval_4_or_8_config  output  1  ICW1 D2.
single_or_cascade_config  output  1  ICW1 D1.
set_icw4_config  output  1  ICW1 D0.
interrupt_vector_address_high  output  8  ICW2.
cascade_device_config  output  CASCADE_LINES  ICW3: master slave mask, or slave ID in the low bits.
special_fully_nested_config  output  1  ICW4 D4.
buffered_mode_config  output  1  ICW4 D3.
buffered_master_or_slave_config  output  1  ICW4 D2.
auto_eoi_config  output  1  ICW4 D1.
microprocessor_mode_config  output  1  ICW4 D0.
initialization_start  output  1  one-cycle pulse after an ICW1 write.
initialization_in_progress  output  1  high in the WAIT_ICW2, WAIT_ICW3 and WAIT_ICW4 states.
initialization_done  output  1  high in the READY state.
write_operation_control_word_1  output  1  one-cycle OCW1 strobe.
write_operation_control_word_2  output  1  one-cycle OCW2 strobe.
write_operation_control_word_3  output  1  one-cycle OCW3 strobe.

Behaviour:
- Reset (async assert, sync release):
  - State is UNINIT.
  - All config outputs, strobes and status outputs are 0, except microprocessor_mode_config, which is 1 when SUPPORT_MCS80=0.
- ICW1 is decoded as write_strobe=1, address_a0=0, D4=1, in any state:
  - ICW1 fields are captured on that edge.
  - The ICW4 fields are cleared to 0; microprocessor_mode_config is set to !SUPPORT_MCS80.
  - ICW2 and ICW3 registers are kept.
  - The next state is WAIT_ICW2.
  - initialization_start pulses for the following cycle.
  - An ICW1 mid-sequence restarts the sequence.
- States (a "write" below means write_strobe=1):
  - UNINIT: any non-ICW1 write is ignored; no OCW strobes are issued.
  - WAIT_ICW2, write with a0=1: capture ICW2. Next state is WAIT_ICW3 if single_or_cascade_config=0, else WAIT_ICW4 if set_icw4_config=1, else READY.
  - WAIT_ICW3, write with a0=1: capture D[CASCADE_LINES-1:0]. Next state is WAIT_ICW4 if set_icw4_config=1, else READY.
  - WAIT_ICW4, write with a0=1: capture D4-D0. Next state is READY.
  - WAIT_* states, write with a0=0 and D4=0: ignored; state is held.
  - READY, write with a0=1: write_operation_control_word_1 pulses.
  - READY, write with a0=0, D4=0, D3=0: write_operation_control_word_2 pulses.
  - READY, write with a0=0, D4=0, D3=1: write_operation_control_word_3 pulses.
- Latency: captured fields and OCW strobes appear the cycle after the write edge (registered outputs). At most one strobe is high per cycle.
- SUPPORT_MCS80=0: interrupt_vector_address and call_address_interval_4_or_8_config are held at 0. The ICW4 D0 write is ignored and microprocessor_mode_config stays 1.
- Back-to-back writes on consecutive cycles are each processed; there is no dead cycle.
- A reset asserted mid-sequence returns to UNINIT immediately and clears all outputs as above.

Test Plan:
- Reset, then OCW write (a0=1, D=0xFF) -> no strobe; initialization_done=0.
- ICW1 0x13 (edge, single, IC4), ICW2 0x08, ICW4 0x01 -> initialization_start pulses once; state skips WAIT_ICW3; initialization_done=1; interrupt_vector_address_high=0x08; microprocessor_mode_config=1; single_or_cascade_config=1.
- Cascade master: ICW1 0x11, ICW2 0x20, ICW3 0x04, ICW4 0x1D -> cascade_device_config=0x04; special_fully_nested_config=1; buffered_mode_config=1; buffered_master_or_slave_config=1; microprocessor_mode_config=1.
- In READY: writes (a0=1, 0xFB), (a0=0, 0x20), (a0=0, 0x0B) on consecutive cycles -> OCW1, OCW2, OCW3 strobes each high exactly one cycle, in order.
- Mid-sequence ICW1 0x1B after ICW2 -> back to WAIT_ICW2; ICW4 fields read 0 (microprocessor_mode_config=0 with SUPPORT_MCS80=1); level_or_edge_triggered_config=1.
- SUPPORT_MCS80=0, CASCADE_LINES=4: ICW1 0xF4, ICW2 0x40 -> interrupt_vector_address=0; call_address_interval_4_or_8_config=0; cascade ICW3 0xFA captures 0xA; async reset during WAIT_ICW3 -> all outputs reset the same cycle.
